shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational barrelshifter instance between two requesters.
- Round-robin arbitration with valid/ready handshakes.
- Result, flags and requester ID are captured in a one-entry output register.
- Sits between two execution sources, for example the ALU issue port and the address-generation unit, and the shared shifter datapath.

Parameters:
- D_SIZE, 32, data width. Must be a power of 2 and at least 4. Shift amount width is $clog2(D_SIZE).

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- req_valid_in  input  2  per-requester request valid; bit i is requester i.
- req_ready_out  output  2  per-requester accept; a request transfers when valid and ready are both high on the clock edge.
- req0_x_in / req1_x_in  input  D_SIZE  operand.
- req0_s_in / req1_s_in  input  $clog2(D_SIZE)  shift amount.
- req0_op_in / req1_op_in  input  3  opcode (see Behaviour).
- res_valid_out  output  1  output register holds a result.
- res_ready_in  input  1  consumer accepts the result.
- res_y_out  output  D_SIZE  shifted result.
- res_zf_out  output  1  zero flag.
- res_vf_out  output  1  overflow flag.
- res_id_out  output  1  index of the requester that produced the result.
- stat0_out / stat1_out  output  16  accepted-request counters (see Optional Feature).

Behaviour:
- Opcodes:
  - 000 SRL, 001 SRA, 01? ROR.
  - 100 SLL, 101 ASL (sign bit preserved), 11? ROL.
  - zf = result all zero.
  - vf set only for ASL, when any shifted-out bit differs from x[msb]; vf = 0 for all other ops.
- Reset (rst_n_in low, asynchronous):
  - res_valid_out = 0; res_y_out = 0; res_zf_out = 0; res_vf_out = 0; res_id_out = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - Stat counters = 0.
  - An in-flight result is discarded. Requests presented during reset are not accepted.
- slot_free = !res_valid_out || res_ready_in. This allows drain and refill in the same cycle, giving a throughput of 1 result/cycle.
- Grant (combinational):
  - Only one request valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
- req_ready_out[g] = slot_free && grant valid. The other bit is 0. At most one ready bit is high per cycle.
- Ready never depends on the data/op inputs. Requesters hold valid and payload stable until accepted; the arbiter does not require this for correctness.
- On accept (clock edge):
  - The selected payload is muxed into the shifter.
  - y/zf/vf/id are registered and res_valid_out = 1.
  - last_grant = g.
- Latency: 1 cycle from accept edge to res_valid_out.
- Hold: while res_valid_out && !res_ready_in, all res_* outputs stay stable and req_ready_out = 00.
- Drain without new accept: res_valid_out -> 0; data outputs keep their last value.
- FSM (2 states):
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain+accept, or on stall.
  - FULL -> EMPTY on drain with no accept.
- last_grant updates only on actual accepts. A lone requester never changes fairness order for future contention beyond its own grant.
- s_in = 0: every op returns x unchanged and vf = 0.

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- Defined:
  - stat0_out/stat1_out count accepted requests per requester.
  - 16-bit, saturating at 16'hFFFF (no wrap).
  - Cleared only by reset.
- Undefined: no counter registers exist; stat0_out and stat1_out are tied to 0.
- Port list is identical in both builds.

Test Plan:
- D_SIZE=8, req0 only: x=8'hB4, s=1, op=000, res_ready=1 -> next cycle res_valid=1, y=8'h5A, zf=0, vf=0, id=0.
- ASL overflow: req1 x=8'h30, s=2, op=101 -> y=8'h40, vf=1, id=1. Rotate: x=8'h81, s=1, op=010 -> y=8'hC0, vf=0. Zero: x=8'h01, s=1, op=000 -> y=8'h00, zf=1.
- Contention: both valid every cycle from reset, res_ready=1 -> req_ready sequence 01,10,01,10; res_id sequence 0,1,0,1; one result per cycle, no gaps.
- Backpressure: result held with res_ready=0 for 3 cycles -> req_ready=00, res_* stable. Raise res_ready -> drain and next accept on the same edge; res_valid stays 1.
- Reset mid-operation: pull rst_n_in low while res_valid=1 (between edges) -> res_valid=0 immediately. After release with both requesters valid, the first grant goes to requester 0.
- With SHIFT_ARB_STATS_EN: 5 accepts req0 and 3 accepts req1 -> stat0=5, stat1=3. Force 16'hFFFF then one more accept -> stays 16'hFFFF. Without the macro -> both stats read 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational barrel shifter between two requesters.
// Latency: 1 cycle from accept edge to res_valid_out; one result per cycle when the consumer keeps up.
// Backpressure: req_ready_out drops to 00 while a held result is not taken (res_valid_out && !res_ready_in).
//
// Ports:
//   clk_in, rst_n_in             clock, asynchronous active-low reset
//   req_valid_in/req_ready_out   per-requester handshake, bit i = requester i
//   reqN_x_in/_s_in/_op_in       operand, shift amount, opcode of requester N
//   res_valid_out/res_ready_in   output register handshake
//   res_y/zf/vf/id_out           result, zero flag, ASL overflow flag, producing requester
//   stat0_out/stat1_out          saturating accept counters (only with SHIFT_ARB_STATS_EN, else 0)
//
// Opcodes: 000 SRL, 001 SRA, 01x ROR, 100 SLL, 101 ASL (sign preserved), 11x ROL.
// Build option: define SHIFT_ARB_STATS_EN to add the per-requester accept counters.
module shift_arbiter #(
    parameter  int D_SIZE = 32,
    localparam int S_W    = $clog2(D_SIZE)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [1:0]        req_valid_in,
    output logic [1:0]        req_ready_out,
    input  logic [D_SIZE-1:0] req0_x_in,
    input  logic [S_W-1:0]    req0_s_in,
    input  logic [2:0]        req0_op_in,
    input  logic [D_SIZE-1:0] req1_x_in,
    input  logic [S_W-1:0]    req1_s_in,
    input  logic [2:0]        req1_op_in,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [D_SIZE-1:0] res_y_out,
    output logic              res_zf_out,
    output logic              res_vf_out,
    output logic              res_id_out,
    output logic [15:0]       stat0_out,
    output logic [15:0]       stat1_out
);

    typedef struct packed {
        logic [D_SIZE-1:0] y;
        logic              zf;
        logic              vf;
        logic              id;
    } res_t;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t state_q, state_d;
    res_t   res_q, res_d;
    logic   last_grant_q, last_grant_d;

    logic   slot_free;
    logic   grant_vld;
    logic   grant_id;
    logic   accept;

    logic [D_SIZE-1:0]   sel_x;
    logic [S_W-1:0]      sel_s;
    logic [2:0]          sel_op;
    logic [D_SIZE-1:0]   shf_y;
    logic                shf_vf;
    logic [D_SIZE-1:0]   lin_sh;
    logic [2*D_SIZE-1:0] rot_sh;

    // ------------------------------------------------------------------
    // Arbitration. Ready is a function of valid bits and slot state only,
    // never of payload. Gated by reset so nothing is offered while held.
    // ------------------------------------------------------------------
    assign slot_free = (state_q == ST_EMPTY) || res_ready_in;
    assign grant_vld = |req_valid_in;

    always_comb begin
        grant_id = 1'b0;
        unique case (req_valid_in)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant_q;  // alternate under contention
            default: grant_id = 1'b0;
        endcase
    end

    assign accept        = rst_n_in && slot_free && grant_vld;
    assign req_ready_out = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------------------------
    // Payload mux and shared shifter
    // ------------------------------------------------------------------
    always_comb begin
        sel_x  = grant_id ? req1_x_in  : req0_x_in;
        sel_s  = grant_id ? req1_s_in  : req0_s_in;
        sel_op = grant_id ? req1_op_in : req0_op_in;
    end

    always_comb begin
        shf_y  = '0;
        shf_vf = 1'b0;
        lin_sh = '0;
        rot_sh = '0;
        case (sel_op)
            3'b000: shf_y = sel_x >> sel_s;
            3'b001: shf_y = $signed(sel_x) >>> sel_s;
            3'b010, 3'b011: begin
                rot_sh = {sel_x, sel_x} >> sel_s;
                shf_y  = rot_sh[D_SIZE-1:0];
            end
            3'b100: shf_y = sel_x << sel_s;
            3'b101: begin
                // Sign bit stays put; magnitude bits x[msb-1:0] shift left.
                // Overflow when any bit leaving the magnitude field differs
                // from the sign, i.e. bits i with i + s >= msb.
                lin_sh = sel_x << sel_s;
                shf_y  = {sel_x[D_SIZE-1], lin_sh[D_SIZE-2:0]};
                for (int i = 0; i < D_SIZE - 1; i++) begin
                    if ((i + int'(sel_s)) >= (D_SIZE - 1) && (sel_x[i] != sel_x[D_SIZE-1])) begin
                        shf_vf = 1'b1;
                    end
                end
            end
            default: begin
                rot_sh = {sel_x, sel_x} << sel_s;
                shf_y  = rot_sh[2*D_SIZE-1:D_SIZE];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register, fairness pointer, FSM
    // ------------------------------------------------------------------
    always_comb begin
        res_d        = res_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            res_d.y      = shf_y;
            res_d.zf     = (shf_y == '0);
            res_d.vf     = shf_vf;
            res_d.id     = grant_id;
            last_grant_d = grant_id;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (res_ready_in && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_EMPTY;
            res_q        <= '0;
            last_grant_q <= 1'b1;  // requester 0 wins the first contention
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid_out = (state_q == ST_FULL);
    assign res_y_out     = res_q.y;
    assign res_zf_out    = res_q.zf;
    assign res_vf_out    = res_q.vf;
    assign res_id_out    = res_q.id;

    // ------------------------------------------------------------------
    // Accept counters
    // ------------------------------------------------------------------
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] stat0_q, stat0_d;
    logic [15:0] stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (accept && !grant_id && stat0_q != 16'hFFFF) stat0_d = stat0_q + 16'd1;
        if (accept &&  grant_id && stat1_q != 16'hFFFF) stat1_d = stat1_q + 16'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat0_out = stat0_q;
    assign stat1_out = stat1_q;
`else
    assign stat0_out = 16'h0000;
    assign stat1_out = 16'h0000;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Purpose: directed self-checking bench for shift_arbiter at D_SIZE=8.
// Latency: expects results one clock after the accepting edge.
// Backpressure: exercises consumer stall, same-edge drain/refill and drain-only.
module tb_shift_arbiter;

    localparam int DW = 8;
    localparam int SW = 3;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [1:0]    req_valid_in;
    logic [1:0]    req_ready_out;
    logic [DW-1:0] req0_x_in, req1_x_in;
    logic [SW-1:0] req0_s_in, req1_s_in;
    logic [2:0]    req0_op_in, req1_op_in;
    logic          res_valid_out;
    logic          res_ready_in;
    logic [DW-1:0] res_y_out;
    logic          res_zf_out, res_vf_out, res_id_out;
    logic [15:0]   stat0_out, stat1_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    shift_arbiter #(.D_SIZE(DW)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req0_x_in     (req0_x_in),
        .req0_s_in     (req0_s_in),
        .req0_op_in    (req0_op_in),
        .req1_x_in     (req1_x_in),
        .req1_s_in     (req1_s_in),
        .req1_op_in    (req1_op_in),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_y_out     (res_y_out),
        .res_zf_out    (res_zf_out),
        .res_vf_out    (res_vf_out),
        .res_id_out    (res_id_out),
        .stat0_out     (stat0_out),
        .stat1_out     (stat1_out)
    );

    task automatic test_reset();
        rst_n_in     = 1'b0;
        req_valid_in = 2'b11;
        res_ready_in = 1'b1;
        req0_x_in = 8'h00; req0_s_in = 3'd0; req0_op_in = 3'b000;
        req1_x_in = 8'h00; req1_s_in = 3'd0; req1_op_in = 3'b000;
        @(negedge clk_in);
        checks++;
        if (res_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", res_valid_out); end
        checks++;
        if ({res_y_out, res_zf_out, res_vf_out, res_id_out} !== 11'h000) begin
            errors++; $display("FAIL reset_res got y=%h zf=%b vf=%b id=%b exp all 0", res_y_out, res_zf_out, res_vf_out, res_id_out);
        end
        checks++;
        if (req_ready_out !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready_out); end
        checks++;
        if (stat0_out !== 16'h0 || stat1_out !== 16'h0) begin
            errors++; $display("FAIL reset_stats got %h/%h exp 0/0", stat0_out, stat1_out);
        end
        @(negedge clk_in);
        rst_n_in     = 1'b1;
        req_valid_in = 2'b00;
    endtask

    task automatic test_basic();
        req0_x_in = 8'hB4; req0_s_in = 3'd1; req0_op_in = 3'b000;
        req_valid_in = 2'b01;
        #1;
        checks++;
        if (req_ready_out !== 2'b01) begin errors++; $display("FAIL basic_ready got %b exp 01", req_ready_out); end
        @(negedge clk_in);
        checks++;
        if ({res_valid_out, res_y_out, res_zf_out, res_vf_out, res_id_out} !== {1'b1, 8'h5A, 3'b000}) begin
            errors++; $display("FAIL basic_res got v=%b y=%h zf=%b vf=%b id=%b exp v=1 y=5a zf=0 vf=0 id=0",
                               res_valid_out, res_y_out, res_zf_out, res_vf_out, res_id_out);
        end
        req_valid_in = 2'b00;
    endtask

    // Back-to-back accepts on requester 1, one opcode vector per cycle.
    task automatic test_ops();
        logic [7:0] xs  [11];
        logic [2:0] ss  [11];
        logic [2:0] ops [11];
        logic [7:0] ey  [11];
        logic       ezf [11];
        logic       evf [11];
        xs  = '{8'h30, 8'h81, 8'h01, 8'h80, 8'h81, 8'h81, 8'hC3, 8'hE0, 8'h0F, 8'h12, 8'h40};
        ss  = '{3'd2,  3'd1,  3'd1,  3'd3,  3'd1,  3'd1,  3'd0,  3'd2,  3'd4,  3'd3,  3'd1};
        ops = '{3'b101, 3'b010, 3'b000, 3'b001, 3'b100, 3'b110, 3'b101, 3'b101, 3'b011, 3'b111, 3'b101};
        ey  = '{8'h40, 8'hC0, 8'h00, 8'hF0, 8'h02, 8'h03, 8'hC3, 8'h80, 8'hF0, 8'h90, 8'h00};
        ezf = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        evf = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        req_valid_in = 2'b10;
        for (int i = 0; i < 11; i++) begin
            req1_x_in = xs[i]; req1_s_in = ss[i]; req1_op_in = ops[i];
            @(negedge clk_in);
            checks++;
            if ({res_valid_out, res_y_out, res_zf_out, res_vf_out, res_id_out} !== {1'b1, ey[i], ezf[i], evf[i], 1'b1}) begin
                errors++; $display("FAIL op_vec%0d got v=%b y=%h zf=%b vf=%b id=%b exp v=1 y=%h zf=%b vf=%b id=1",
                                   i, res_valid_out, res_y_out, res_zf_out, res_vf_out, res_id_out, ey[i], ezf[i], evf[i]);
            end
        end
        req_valid_in = 2'b00;
        @(negedge clk_in);
    endtask

    task automatic test_contention();
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        req0_x_in = 8'h10; req0_s_in = 3'd1; req0_op_in = 3'b000;  // -> 08
        req1_x_in = 8'h10; req1_s_in = 3'd1; req1_op_in = 3'b100;  // -> 20
        res_ready_in = 1'b1;
        req_valid_in = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req_ready_out !== ((i % 2) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL contention_ready%0d got %b exp %b", i, req_ready_out, (i % 2) ? 2'b10 : 2'b01);
            end
            @(negedge clk_in);
            checks++;
            if ({res_valid_out, res_id_out, res_y_out} !== {1'b1, (i % 2) == 1, ((i % 2) ? 8'h20 : 8'h08)}) begin
                errors++; $display("FAIL contention_res%0d got v=%b id=%b y=%h exp v=1 id=%0d y=%h",
                                   i, res_valid_out, res_id_out, res_y_out, i % 2, (i % 2) ? 8'h20 : 8'h08);
            end
        end
    endtask

    // Starts holding the requester-1 result from the contention run.
    task automatic test_backpressure();
        res_ready_in = 1'b0;
        #1;
        checks++;
        if (req_ready_out !== 2'b00) begin errors++; $display("FAIL stall_ready0 got %b exp 00", req_ready_out); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            checks++;
            if ({res_valid_out, res_y_out, res_zf_out, res_vf_out, res_id_out, req_ready_out} !== {1'b1, 8'h20, 3'b001, 2'b00}) begin
                errors++; $display("FAIL stall_hold%0d got v=%b y=%h zf=%b vf=%b id=%b rdy=%b exp v=1 y=20 zf=0 vf=0 id=1 rdy=00",
                                   k, res_valid_out, res_y_out, res_zf_out, res_vf_out, res_id_out, req_ready_out);
            end
        end
        res_ready_in = 1'b1;
        #1;
        checks++;
        if (req_ready_out !== 2'b01) begin errors++; $display("FAIL refill_ready got %b exp 01", req_ready_out); end
        @(negedge clk_in);
        checks++;
        if ({res_valid_out, res_id_out, res_y_out} !== {1'b1, 1'b0, 8'h08}) begin
            errors++; $display("FAIL refill_res got v=%b id=%b y=%h exp v=1 id=0 y=08", res_valid_out, res_id_out, res_y_out);
        end
        req_valid_in = 2'b00;
        @(negedge clk_in);
        checks++;
        if ({res_valid_out, res_y_out} !== {1'b0, 8'h08}) begin
            errors++; $display("FAIL drain got v=%b y=%h exp v=0 y=08", res_valid_out, res_y_out);
        end
    endtask

    task automatic test_reset_mid();
        req0_x_in = 8'hB4; req0_s_in = 3'd1; req0_op_in = 3'b000;
        req_valid_in = 2'b01;
        @(negedge clk_in);
        checks++;
        if (res_valid_out !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", res_valid_out); end
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({res_valid_out, res_y_out} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL midrst_clear got v=%b y=%h exp v=0 y=00", res_valid_out, res_y_out);
        end
        req1_x_in = 8'h10; req1_s_in = 3'd1; req1_op_in = 3'b100;
        req_valid_in = 2'b11;
        #1;
        checks++;
        if (req_ready_out !== 2'b00) begin errors++; $display("FAIL midrst_ready_in_reset got %b exp 00", req_ready_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        checks++;
        if (req_ready_out !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got %b exp 01", req_ready_out); end
        @(negedge clk_in);
        checks++;
        if ({res_valid_out, res_id_out, res_y_out} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++; $display("FAIL midrst_res got v=%b id=%b y=%h exp v=1 id=0 y=5a", res_valid_out, res_id_out, res_y_out);
        end
        req_valid_in = 2'b00;
        @(negedge clk_in);
    endtask

    task automatic test_stats();
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        res_ready_in = 1'b1;
        req_valid_in = 2'b01;
        repeat (5) @(negedge clk_in);
        req_valid_in = 2'b10;
        repeat (3) @(negedge clk_in);
        req_valid_in = 2'b00;
        @(negedge clk_in);
`ifdef SHIFT_ARB_STATS_EN
        checks++;
        if (stat0_out !== 16'd5 || stat1_out !== 16'd3) begin
            errors++; $display("FAIL stats_count got %0d/%0d exp 5/3", stat0_out, stat1_out);
        end
        force dut.stat0_q = 16'hFFFF;
        #1;
        release dut.stat0_q;
        req_valid_in = 2'b01;
        @(negedge clk_in);
        req_valid_in = 2'b00;
        @(negedge clk_in);
        checks++;
        if (stat0_out !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got %h exp ffff", stat0_out); end
`else
        checks++;
        if (stat0_out !== 16'd0 || stat1_out !== 16'd0) begin
            errors++; $display("FAIL stats_disabled got %0d/%0d exp 0/0", stat0_out, stat1_out);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
